// File: rtl/intr_controller.sv
`timescale 1ns/1ps
// intr_controller: memory-mapped interrupt controller on the shared device bus.
// Latches device edges as pending, masks them with an enable register, picks one
// winner and drives a single irq through a claim / end-of-interrupt handshake.
// Optional round-robin arbitration: define INTC_ROTATE_PRIO_EN.
module intr_controller #(
  parameter int unsigned      DBITS    = 32,
  parameter int unsigned      NDEV     = 4,
  parameter logic [DBITS-1:0] IE_ADDR  = DBITS'(32'hF000_0200),
  parameter logic [DBITS-1:0] IP_ADDR  = DBITS'(32'hF000_0204),
  parameter logic [DBITS-1:0] ID_ADDR  = DBITS'(32'hF000_0208),
  parameter logic [DBITS-1:0] EOI_ADDR = DBITS'(32'hF000_020C)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] address,
  inout  wire  [DBITS-1:0] dbus,
  input  logic [NDEV-1:0]  devIrq,
  output logic             irq
);

  localparam int unsigned IDW = 4;
  localparam int unsigned SW  = IDW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t          r_state;
  logic [NDEV-1:0] r_ie;
  logic [NDEV-1:0] r_ip;
  logic [NDEV-1:0] r_prev;
  logic            r_armed;
  logic [IDW-1:0]  r_cur_id;
  logic            r_irq;

  logic [NDEV-1:0]  w_edge;
  logic [NDEV-1:0]  w_cand;
  logic [NDEV-1:0]  w_clr;
  logic [NDEV-1:0]  w_ip_next;
  logic [IDW-1:0]   w_winner;
  logic             w_valid;
  logic             w_rd;
  logic             w_claim;
  logic             w_ie_wr;
  logic             w_ip_wr;
  logic             w_eoi_wr;
  logic             w_oe;
  logic [DBITS-1:0] w_rd_data;
  logic             w_unused;

  // r_armed masks the first cycle after reset so a line already high is not an edge
  assign w_edge   = devIrq & ~r_prev & {NDEV{r_armed}};
  assign w_cand   = r_ip & r_ie;
  assign w_valid  = (r_state == S_ASSERT) && (|w_cand);
  assign w_rd     = !wrtEn;
  assign w_claim  = w_rd && (address == ID_ADDR) && w_valid;
  assign w_ie_wr  = wrtEn && (address == IE_ADDR);
  assign w_ip_wr  = wrtEn && (address == IP_ADDR);
  assign w_eoi_wr = wrtEn && (address == EOI_ADDR);
  assign w_unused = ^dbus[DBITS-1:NDEV];

`ifdef INTC_ROTATE_PRIO_EN
  logic [IDW-1:0]    r_last;
  logic [IDW-1:0]    w_start;
  logic [2*NDEV-1:0] w_dbl;
  logic [NDEV-1:0]   w_rot;
  logic [IDW-1:0]    w_pos;
  logic [SW-1:0]     w_sum;

  assign w_start = (r_last == IDW'(NDEV - 1)) ? '0 : r_last + IDW'(1);
  assign w_dbl   = {w_cand, w_cand};
  assign w_rot   = NDEV'(w_dbl >> w_start);

  // Round-robin winner: first set bit of the rotated candidates, mapped back
  always_comb begin
    w_pos = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = IDW'(i);
    end
    w_sum = SW'(w_pos) + SW'(w_start);
    if (w_sum >= SW'(NDEV)) w_sum = w_sum - SW'(NDEV);
    w_winner = w_sum[IDW-1:0];
  end
`else
  // Fixed-priority winner: lowest set index of the candidates
  always_comb begin
    w_winner = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (w_cand[i]) w_winner = IDW'(i);
    end
  end
`endif

  // Pending clear sources: W1C write and the claimed winner
  always_comb begin
    w_clr = '0;
    if (w_ip_wr) w_clr = dbus[NDEV-1:0];
    for (int i = 0; i < NDEV; i++) begin
      if (w_claim && (w_winner == IDW'(i))) w_clr[i] = 1'b1;
    end
  end

  // A new edge overrides any clear in the same cycle
  assign w_ip_next = (r_ip & ~w_clr) | w_edge;

  // Combinational read mux for the mapped registers
  always_comb begin
    w_oe      = 1'b0;
    w_rd_data = '0;
    if (w_rd) begin
      if (address == IE_ADDR) begin
        w_oe      = 1'b1;
        w_rd_data = DBITS'(r_ie);
      end else if (address == IP_ADDR) begin
        w_oe      = 1'b1;
        w_rd_data = DBITS'(r_ip);
      end else if (address == ID_ADDR) begin
        w_oe                   = 1'b1;
        w_rd_data[DBITS-1]     = w_valid;
        w_rd_data[IDW-1:0]     = w_winner;
      end else if (address == EOI_ADDR) begin
        w_oe      = 1'b1;
        w_rd_data = DBITS'({r_cur_id, (r_state == S_SERVICE)});
      end
    end
  end

  assign dbus = w_oe ? w_rd_data : {DBITS{1'bz}};

  // Edge capture, pending and enable registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev  <= '0;
      r_armed <= 1'b0;
      r_ip    <= '0;
      r_ie    <= '0;
    end else begin
      r_prev  <= devIrq;
      r_armed <= 1'b1;
      r_ip    <= w_ip_next;
      if (w_ie_wr) r_ie <= dbus[NDEV-1:0];
    end
  end

  // Claim/complete sequencer with registered irq
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cur_id <= '0;
      r_irq    <= 1'b0;
`ifdef INTC_ROTATE_PRIO_EN
      r_last   <= IDW'(NDEV - 1);
`endif
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_cand) begin
            r_state <= S_ASSERT;
            r_irq   <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (!(|w_cand)) begin
            r_state <= S_IDLE;
          end else if (w_claim) begin
            r_state  <= S_SERVICE;
            r_cur_id <= w_winner;
`ifdef INTC_ROTATE_PRIO_EN
            r_last   <= w_winner;
`endif
          end else begin
            r_irq <= 1'b1;
          end
        end
        S_SERVICE: begin
          if (w_eoi_wr) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_intr_controller.sv
`timescale 1ns/1ps
// tb_intr_controller: directed scenarios plus randomized traffic against a
// behavioural model of the interrupt controller.
module tb_intr_controller;

  localparam logic [31:0] IE_A  = 32'hF000_0200;
  localparam logic [31:0] IP_A  = 32'hF000_0204;
  localparam logic [31:0] ID_A  = 32'hF000_0208;
  localparam logic [31:0] EOI_A = 32'hF000_020C;
  localparam logic [31:0] UNM_A = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  dev = 4'h0;
  logic        irq;
  logic        tb_oe = 1'b1;
  logic [31:0] tb_data = 32'h0;
  wire  [31:0] dbus;

  int checks = 0;
  int failures = 0;

  assign dbus = tb_oe ? tb_data : 32'bz;

  intr_controller dut (
    .clk(clk), .reset(reset), .wrtEn(we), .address(addr),
    .dbus(dbus), .devIrq(dev), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit [3:0] m_ie, m_ip, m_prev;
  bit       m_fresh;
  int       m_phase;   // 0 waiting, 1 requesting, 2 in service
  int       m_cur, m_last;
  bit       m_irq;

  function automatic int m_winner(bit [3:0] c);
`ifdef INTC_ROTATE_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_last + 1 + k) % 4;
      if (c[i]) return i;
    end
`else
    for (int i = 0; i < 4; i++) if (c[i]) return i;
`endif
    return 0;
  endfunction

  function automatic bit m_valid();
    return (m_phase == 1) && ((m_ie & m_ip) != 0);
  endfunction

  function automatic logic [31:0] m_rd(logic [31:0] a);
    if (a == IE_A)  return {28'b0, m_ie};
    if (a == IP_A)  return {28'b0, m_ip};
    if (a == EOI_A) return 32'(m_cur * 2 + ((m_phase == 2) ? 1 : 0));
    return (m_valid() ? 32'h8000_0000 : 32'h0) | 32'(m_winner(m_ie & m_ip));
  endfunction

  task automatic m_reset();
    m_ie = 0; m_ip = 0; m_prev = 0; m_fresh = 1;
    m_phase = 0; m_cur = 0; m_last = 3; m_irq = 0;
  endtask

  task automatic m_step();
    bit [3:0] c, edges, nip;
    bit claim;
    int w;
    c     = m_ie & m_ip;
    w     = m_winner(c);
    edges = m_fresh ? 4'h0 : (dev & ~m_prev);
    claim = !we && (addr == ID_A) && (m_phase == 1) && (c != 0);
    nip   = m_ip;
    if (we && addr == IP_A) nip = nip & ~tb_data[3:0];
    if (claim) nip[w] = 1'b0;
    nip = nip | edges;
    if (we && addr == IE_A) m_ie = tb_data[3:0];
    case (m_phase)
      0: if (c != 0) m_phase = 1;
      1: if (c == 0) m_phase = 0;
         else if (claim) begin m_phase = 2; m_cur = w; m_last = w; end
      default: if (we && addr == EOI_A) m_phase = 0;
    endcase
    m_ip    = nip;
    m_prev  = dev;
    m_fresh = 0;
    m_irq   = (m_phase == 1);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else m_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("irq_model", {31'b0, irq}, {31'b0, m_irq});
      if (tb_oe) check("dbus_released", dbus, tb_data);
      else if (addr == ID_A && !m_valid()) check("claim_invalid", {31'b0, dbus[31]}, 32'h0);
      else check("dbus_read", dbus, m_rd(addr));
    end
  end

  // ---------------- bus driver ----------------
  function automatic bit mapped(logic [31:0] a);
    return (a == IE_A) || (a == IP_A) || (a == ID_A) || (a == EOI_A);
  endfunction

  task automatic bus_idle();
    we = 1'b0; addr = UNM_A; tb_oe = 1'b1; tb_data = $urandom;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; tb_oe = 1'b1; tb_data = d;
  endtask

  task automatic bus_rd(input logic [31:0] a);
    we = 1'b0; addr = a; tb_oe = !mapped(a); tb_data = $urandom;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    int op;
    bus_idle();
    reset = 1'b0;
    repeat (3) tick();
    bus_rd(IE_A);
    #1 check("reset_ie", dbus, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    tick();
    reset = 1'b1;
    bus_idle();
    repeat (2) tick();

    // basic
    bus_wr(IE_A, 32'h2); tick();
    bus_idle(); dev = 4'b0010; tick();
    bus_rd(IP_A);
    #1 check("basic_ip_t1", dbus, 32'h2);
    check("basic_irq_t1", {31'b0, irq}, 32'h0);
    tick();
    check("basic_irq_t2", {31'b0, irq}, 32'h1);
    bus_rd(ID_A);
    #1 check("basic_claim", dbus, 32'h8000_0001);
    tick();
    bus_rd(IP_A);
    #1 check("basic_ip_claimed", dbus, 32'h0);
    check("basic_irq_service", {31'b0, irq}, 32'h0);
    bus_rd(EOI_A);
    #1 check("basic_insvc", dbus, 32'h3);
    bus_wr(EOI_A, $urandom); tick();
    bus_rd(EOI_A);
    #1 check("basic_eoi_idle", dbus, 32'h2);
    dev = 4'h0; bus_idle(); tick();

    // priority
    bus_wr(IE_A, 32'hF); tick();
    bus_idle(); dev = 4'b1001; tick(); tick();
    bus_rd(ID_A);
`ifdef INTC_ROTATE_PRIO_EN
    #1 check("prio_claim1", dbus, 32'h8000_0003);
`else
    #1 check("prio_claim1", dbus, 32'h8000_0000);
`endif
    tick();
    bus_wr(EOI_A, $urandom); tick();
    bus_idle(); tick();
    check("prio_reassert", {31'b0, irq}, 32'h1);
    bus_rd(ID_A);
`ifdef INTC_ROTATE_PRIO_EN
    #1 check("prio_claim2", dbus, 32'h8000_0000);
`else
    #1 check("prio_claim2", dbus, 32'h8000_0003);
`endif
    tick();
    bus_wr(EOI_A, $urandom); tick();
    dev = 4'h0; bus_idle(); tick();

    // masking
    bus_wr(IE_A, 32'h0); tick();
    bus_idle(); dev = 4'b0100; tick();
    dev = 4'h0;
    bus_rd(IP_A);
    #1 check("mask_ip", dbus, 32'h4);
    check("mask_irq_off", {31'b0, irq}, 32'h0);
    tick();
    check("mask_irq_off2", {31'b0, irq}, 32'h0);
    bus_wr(IE_A, 32'h4); tick();
    bus_idle();
    #1 check("mask_irq_pre", {31'b0, irq}, 32'h0);
    tick();
    check("mask_irq_on", {31'b0, irq}, 32'h1);
    bus_wr(IP_A, 32'h4); tick();
    bus_rd(ID_A);
    #1 check("mask_claim_valid", {31'b0, dbus[31]}, 32'h0);
    tick();
    check("mask_irq_drop", {31'b0, irq}, 32'h0);
    bus_idle(); tick();

    // simultaneous set/clear
    bus_wr(IE_A, 32'h2); tick();
    bus_idle(); dev = 4'b0010; tick(); tick();
    dev = 4'h0; tick();
    dev = 4'b0010; bus_rd(ID_A);
    #1 check("sim_claim", dbus, 32'h8000_0001);
    tick();
    bus_rd(IP_A);
    #1 check("sim_ip_kept", dbus, 32'h2);
    bus_rd(EOI_A);
    #1 check("sim_curid", dbus, 32'h3);
    bus_wr(EOI_A, $urandom); tick();
    bus_idle(); tick();
    check("sim_reassert", {31'b0, irq}, 32'h1);
    bus_rd(ID_A);
    #1 check("sim_claim2", dbus, 32'h8000_0001);
    tick();
    bus_wr(EOI_A, $urandom); tick();
    dev = 4'h0; bus_idle(); tick();

    // bus hygiene
    bus_rd(UNM_A);
    #1 check("hyg_unmapped", dbus, tb_data);
    d = ($urandom & 32'hFFFF_FFF0) | 32'h2;
    bus_wr(IE_A, d);
    #1 check("hyg_write", dbus, d);
    tick();
    bus_wr(EOI_A, $urandom); tick();
    bus_rd(EOI_A);
    #1 check("hyg_eoi_idle", dbus, 32'h2);
    bus_idle(); dev = 4'b0010; tick(); tick();
    bus_rd(ID_A);
    #1 check("hyg_claim", dbus, 32'h8000_0001);
    tick();
    bus_rd(ID_A);
    #1 check("hyg_claim_svc", {31'b0, dbus[31]}, 32'h0);
    tick();
    bus_rd(EOI_A);
    #1 check("hyg_still_svc", dbus, 32'h3);

    // async reset mid-service
    dev = 4'hF; bus_rd(IP_A); tick();
    #1 check("rst_pre_ip", dbus, 32'hD);
    @(posedge clk); #3;
    reset = 1'b0;
    #1 check("rst_ip_now", dbus, 32'h0);
    check("rst_irq_now", {31'b0, irq}, 32'h0);
    bus_rd(IE_A);
    #1 check("rst_ie_now", dbus, 32'h0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    bus_rd(IP_A);
    #1 check("rst_no_spurious", dbus, 32'h0);
    check("rst_irq_idle", {31'b0, irq}, 32'h0);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n == 1000 || n == 2000) begin
        @(posedge clk); #3;
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) dev[i] = ~dev[i];
      op = $urandom_range(15);
      case (op)
        0, 1, 2: bus_idle();
        3:       bus_rd(UNM_A);
        4:       bus_rd(IE_A);
        5:       bus_rd(IP_A);
        6:       bus_rd(EOI_A);
        7, 8, 9: bus_rd(ID_A);
        10, 11:  bus_wr(IE_A, $urandom);
        12:      bus_wr(IP_A, $urandom);
        13:      bus_wr(EOI_A, $urandom);
        14:      bus_wr(UNM_A, $urandom);
        default: bus_wr(IE_A, 32'hF);
      endcase
      tick();
    end

    bus_idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
